// File: rtl/conv_pkg.sv
// Shared definitions for the conv_dff_pipe slice.
// Provides clog2(), used to size the level counter (LW = clog2(DEPTH + 1)).
package conv_pkg;

    // Ceiling log2, never less than 1 so that a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/conv_dff_pipe_if.sv
// Handshake bundle for conv_dff_pipe.
// Upstream side:   in_valid_i, D_i (to pipe), in_ready_o (from pipe)
// Downstream side: out_valid_o, Q_o, level_o (from pipe), out_ready_i (to pipe)
// Modports: master = the environment driving the pipe, slave = the pipe itself.
interface conv_dff_pipe_if
    import conv_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned LW = clog2(DEPTH + 1);

    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] D_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] Q_o;
    logic [LW-1:0]    level_o;

    modport master (
        output in_valid_i,
        output D_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  Q_o,
        input  level_o
    );

    modport slave (
        input  in_valid_i,
        input  D_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output Q_o,
        output level_o
    );

endinterface

// File: rtl/conv_pipe_stage.sv
// One pipeline slot: a valid bit plus a WIDTH-bit data register.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (data <- {WIDTH{RstVal}})
//   set_i        synchronous flush: valid <- 0, data <- {WIDTH{PstVal}}
//   load_i       stage advances this cycle (already qualified by enable/set)
//   up_valid_i   valid of the upstream slot (or the accept strobe for the head)
//   up_data_i    data of the upstream slot (or D_i for the head)
//   valid_o      registered valid
//   data_o       registered data
module conv_pipe_stage #(
    parameter int unsigned WIDTH  = 1,
    parameter logic        RstVal = 1'b0,
    parameter logic        PstVal = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_i,
    input  logic             load_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (set_i) begin
            valid_d = 1'b0;
            data_d  = {WIDTH{PstVal}};
        end else if (load_i) begin
            valid_d = up_valid_i;
            // A bubble moving in leaves the old data in place.
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{RstVal}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/conv_dff_pipe.sv
// Elastic DFF pipeline of DEPTH stages with valid/ready handshake, bubble collapse,
// global enable, synchronous flush-and-preset and an occupancy counter.
// Ports:
//   clk       clock (rising edge)
//   rst       asynchronous active-high reset
//   Set_i     synchronous flush; clears all beats, presets data to {WIDTH{PstVal}}
//   Enable_i  global clock enable; 0 freezes all state and blocks the handshake
//   bus       slave side of conv_dff_pipe_if (in_valid_i/in_ready_o/D_i,
//             out_valid_o/out_ready_i/Q_o, level_o)
module conv_dff_pipe
    import conv_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned DEPTH  = 2,
    parameter logic        RstVal = 1'b0,
    parameter logic        PstVal = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Set_i,
    input  logic             Enable_i,
    conv_dff_pipe_if.slave   bus
);
    localparam int unsigned LW = clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] data [DEPTH];

    logic          live;
    logic          accept;
    logic          pop;
    logic [LW-1:0] level_d, level_q;

    // Handshake is only open when enabled, not flushing and out of reset.
    assign live = Enable_i & ~Set_i & ~rst;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (k == 0) begin : g_head
            assign up_valid = accept;
            assign up_data  = bus.D_i;
        end else begin : g_body
            assign up_valid = valid[k-1];
            assign up_data  = data[k-1];
        end

        // Flattened form of adv[k] = ~valid[k] | adv[k+1]: a stage can move whenever any
        // slot at or after it is empty, or the output is being drained.
        assign adv[k] = bus.out_ready_i | ~(&valid[DEPTH-1:k]);

        conv_pipe_stage #(
            .WIDTH  (WIDTH),
            .RstVal (RstVal),
            .PstVal (PstVal)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .set_i      (Set_i),
            .load_i     (Enable_i & ~Set_i & adv[k]),
            .up_valid_i (up_valid),
            .up_data_i  (up_data),
            .valid_o    (valid[k]),
            .data_o     (data[k])
        );
    end

    assign bus.in_ready_o  = live & adv[0];
    assign bus.out_valid_o = live & valid[DEPTH-1];
    assign bus.Q_o         = data[DEPTH-1];

    assign accept = bus.in_valid_i & bus.in_ready_o;
    assign pop    = bus.out_valid_o & bus.out_ready_i;

    always_comb begin
        level_d = level_q;
        if (Set_i) begin
            level_d = '0;
        end else if (accept && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !accept) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign bus.level_o = level_q;

endmodule

// File: doc/conv_dff_pipe.md
CONV_DFF_PIPE -- requirements
Module: conv_dff_pipe

Interface
REQ-001 Parameter WIDTH, default 1: data bits per stage; legal range is 1 or more.
REQ-002 Parameter DEPTH, default 2: number of pipeline stages; legal range is 1 or more.
REQ-003 Parameter RstVal, default 1'b0: bit replicated WIDTH times into every data register on reset.
REQ-004 Parameter PstVal, default 1'b0: bit replicated WIDTH times into every data register on preset.
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 Set_i  input  1  synchronous flush-and-preset.
REQ-008 Enable_i  input  1  global clock enable.
REQ-009 in_valid_i  input  1  D_i holds a beat.
REQ-010 in_ready_o  output  1  the pipe accepts a beat this cycle.
REQ-011 D_i  input  WIDTH  input data.
REQ-012 out_valid_o  output  1  Q_o holds a beat.
REQ-013 out_ready_i  input  1  downstream takes the beat.
REQ-014 Q_o  output  WIDTH  data of the last stage.
REQ-015 level_o  output  LW  count of valid stages; LW = clog2(DEPTH+1).

Function
REQ-016 State: valid[k] and data[k] for stages k = 0..DEPTH-1; stage 0 is the input stage and stage DEPTH-1 is the output stage.
REQ-017 Advance terms:
- adv[DEPTH-1] = ~valid[DEPTH-1] | out_ready_i
- adv[k] = ~valid[k] | adv[k+1]
- adv[k] is purely combinational; bubbles collapse within a single cycle.
REQ-018 in_ready_o = adv[0] & Enable_i & ~Set_i; it is combinational from out_ready_i.
REQ-019 out_valid_o = valid[DEPTH-1] & Enable_i & ~Set_i.
REQ-020 Q_o = data[DEPTH-1] at all times, including when out_valid_o=0.
REQ-021 Accept occurs when in_valid_i & in_ready_o; pop occurs when out_valid_o & out_ready_i.
REQ-022 Update rule, applied when Enable_i=1, Set_i=0 and adv[k]=1:
- valid[k] loads the upstream valid; for stage 0 that is the accept condition.
- data[k] loads the upstream data only if the upstream valid is 1; otherwise data[k] holds.
REQ-023 When adv[k]=0, stage k holds both valid[k] and data[k].
REQ-024 Latency: a beat accepted at edge N appears with out_valid_o=1 after edge N+DEPTH-1 when there are no stalls; throughput is 1 beat per cycle with out_ready_i held at 1.
REQ-025 Enable_i=0 freezes all state; no accept or pop can occur because of REQ-018 and REQ-019.
REQ-026 Set_i=1 with rst=0, at the next edge:
- all valid cleared
- all data set to {WIDTH{PstVal}}
- level_o set to 0
- Set_i overrides Enable_i=0
- the beat presented in the same cycle is not accepted.
REQ-027 level_o changes each cycle by +1 on accept only, -1 on pop only, and 0 on both or neither; its range is 0..DEPTH and it never wraps.
REQ-028 When full (level_o=DEPTH) and out_ready_i=1, accept and pop occur in the same cycle and level_o stays at DEPTH.
REQ-029 When empty, out_valid_o=0 regardless of in_valid_i in that cycle; there is no combinational pass-through.

Reset
REQ-030 On rst=1, asynchronously: all valid=0, all data={WIDTH{RstVal}}, level_o=0, in_ready_o=0, out_valid_o=0.
REQ-031 rst asserted mid-transfer discards all in-flight beats; the first edge after rst deasserts behaves like an empty pipe.
REQ-032 Reset priority is rst > Set_i > Enable_i.

Structure
REQ-033 The shared package conv_pkg holds the clog2 helper that computes LW.
REQ-034 One sub-module, conv_pipe_stage, holds one valid bit and one WIDTH data register with rst/Set_i/advance/load; the top instantiates it DEPTH times in a generate loop.
REQ-035 The advance chain and the level counter live in the top module.

Verification (WIDTH=8, DEPTH=3, RstVal=0, PstVal=1)
REQ-036 Streaming: rst pulse, then D_i=0x11,0x22,0x33 on consecutive cycles with out_ready_i=1 -> out_valid_o rises 2 cycles after the first accept; Q_o shows 0x11,0x22,0x33 back-to-back; level_o peaks at 3.
REQ-037 Backpressure: out_ready_i=0 while 4 beats are offered -> 3 accepted, in_ready_o=0 with level_o=3; raising out_ready_i -> in_ready_o=1 in the same cycle; order is preserved.
REQ-038 Bubble collapse: push 0xA1, idle 1 cycle, push 0xA2, out_ready_i=0 -> both beats pack into stages 2 and 1, and level_o=2.
REQ-039 Set mid-stream: full pipe, Set_i=1 for 1 cycle with in_valid_i=1 -> next cycle level_o=0, Q_o=0xFF, out_valid_o=0; the beat is not accepted.
REQ-040 Enable and reset: Enable_i=0 for 5 cycles with traffic -> state frozen; then rst asserted between edges -> Q_o=0x00 and level_o=0 immediately, with no clock edge.
